// File: rtl/load_store_unit.sv
// Load/store unit: issues one word-wide memory access at a time on behalf of
// the datapath. Sub-word stores use read-modify-write. Sub-word loads are
// extracted from the read word and then sign- or zero-extended.
module load_store_unit #(
    parameter int ADDR_W  = 7,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              unsigned_ld,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ready
);

    // Wait counter must be able to hold TIMEOUT-1. With no timeout it is a dummy bit.
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int TO_LAST = (TIMEOUT > 0) ? (TIMEOUT - 1) : 0;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RD   = 2'd1,
        S_WR   = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              state_q;
    logic                we_q;
    logic [1:0]          size_q;
    logic                uns_q;
    logic [1:0]          boff_q;
    logic [31:0]         wdata_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                done_q;
    logic                err_q;
    logic [31:0]         rdata_q;
    logic                mem_req_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;

    logic [31:0]         addr_hi_s;
    logic                size_err_s;
    logic                req_err_s;
    logic                timeout_s;
    logic [31:0]         load_word_s;
    logic [31:0]         merged_s;

    // Select the addressed byte or halfword and extend it to 32 bits.
    function automatic logic [31:0] extract_load(input logic [31:0] word,
                                                 input logic [1:0]  sz,
                                                 input logic [1:0]  boff,
                                                 input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = word[{boff, 3'b000} +: 8];
        h = boff[1] ? word[31:16] : word[15:0];
        case (sz)
            2'b00:   r = uns ? {24'd0, b} : {{24{b[7]}}, b};
            2'b01:   r = uns ? {16'd0, h} : {{16{h[15]}}, h};
            default: r = word;
        endcase
        return r;
    endfunction

    // Overlay the right-aligned store data onto the addressed lane(s) of the old word.
    function automatic logic [31:0] merge_store(input logic [31:0] old,
                                                input logic [31:0] wd,
                                                input logic [1:0]  sz,
                                                input logic [1:0]  boff);
        logic [31:0] r;
        r = old;
        case (sz)
            2'b00: r[{boff, 3'b000} +: 8] = wd[7:0];
            2'b01: begin
                if (boff[1]) begin
                    r[31:16] = wd[15:0];
                end else begin
                    r[15:0] = wd[15:0];
                end
            end
            default: r = wd;
        endcase
        return r;
    endfunction

    // Alignment and reserved-size check on the incoming request.
    always_comb begin
        size_err_s = 1'b0;
        case (size)
            2'b00:   size_err_s = 1'b0;
            2'b01:   size_err_s = addr[0];
            2'b10:   size_err_s = (addr[1:0] != 2'b00);
            default: size_err_s = 1'b1;
        endcase
    end

    // Range check: any address bit above the word index makes the request illegal.
    always_comb begin
        addr_hi_s = addr >> (ADDR_W + 2);
        req_err_s = size_err_s | (addr_hi_s != 32'd0);
    end

    // Expiry fires on the cycle the wait counter would reach TIMEOUT.
    always_comb begin
        if (TIMEOUT > 0) begin
            timeout_s = (cnt_q == CNT_W'(TO_LAST));
        end else begin
            timeout_s = 1'b0;
        end
    end

    // Data-path helpers fed from the captured read word.
    always_comb begin
        load_word_s = extract_load(mem_rdata, size_q, boff_q, uns_q);
        merged_s    = merge_store(mem_rdata, wdata_q, size_q, boff_q);
    end

    // Main controller: state, memory handshake and all registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            uns_q       <= 1'b0;
            boff_q      <= 2'b00;
            wdata_q     <= 32'd0;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (req) begin
                        we_q    <= we;
                        size_q  <= size;
                        uns_q   <= unsigned_ld;
                        boff_q  <= addr[1:0];
                        wdata_q <= wdata;
                        cnt_q   <= '0;
                        if (req_err_s) begin
                            state_q <= S_RESP;
                            done_q  <= 1'b1;
                            err_q   <= 1'b1;
                        end else if (we && (size == 2'b10)) begin
                            state_q     <= S_WR;
                            mem_req_q   <= 1'b1;
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= addr[ADDR_W+1:2];
                            mem_wdata_q <= wdata;
                        end else begin
                            state_q    <= S_RD;
                            mem_req_q  <= 1'b1;
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= addr[ADDR_W+1:2];
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        if (we_q) begin
                            // Read half of a sub-word store: keep mem_req high into WR.
                            state_q     <= S_WR;
                            mem_we_q    <= 1'b1;
                            mem_wdata_q <= merged_s;
                            cnt_q       <= '0;
                        end else begin
                            state_q   <= S_RESP;
                            mem_req_q <= 1'b0;
                            rdata_q   <= load_word_s;
                            done_q    <= 1'b1;
                            err_q     <= 1'b0;
                        end
                    end else if (timeout_s) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_WR: begin
                    if (mem_ready) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b0;
                    end else if (timeout_s) begin
                        state_q   <= S_RESP;
                        mem_req_q <= 1'b0;
                        mem_we_q  <= 1'b0;
                        done_q    <= 1'b1;
                        err_q     <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_RESP: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    mem_req_q <= 1'b0;
                    mem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a small word memory model.
module tb_load_store_unit;

    localparam int ADDR_W = 7;

    logic              clk;
    logic              rst_n;
    logic              req;
    logic              we;
    logic [1:0]        size;
    logic              unsigned_ld;
    logic [31:0]       addr;
    logic [31:0]       wdata;
    logic              busy;
    logic              done;
    logic              err;
    logic [31:0]       rdata;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;
    logic              mem_ready;

    logic [31:0]       mem [0:127];
    logic              pl_en;
    logic [ADDR_W-1:0] pl_addr;
    logic [31:0]       pl_data;

    int n_cmp;
    int n_fail;

    int          lat, nrd, nwr, nreq;
    logic        e_o;
    logic [31:0] rd_o, ww_o;
    logic        unst;

    load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(16)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size),
        .unsigned_ld(unsigned_ld), .addr(addr), .wdata(wdata),
        .busy(busy), .done(done), .err(err), .rdata(rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_addr];

    // Memory model: preload port for the bench, otherwise accepted writes.
    always @(posedge clk) begin
        if (pl_en) mem[pl_addr] <= pl_data;
        else if (mem_req && mem_ready && mem_we) mem[mem_addr] <= mem_wdata;
    end

    task automatic preload(input logic [ADDR_W-1:0] a, input logic [31:0] d);
        @(negedge clk);
        pl_en = 1'b1; pl_addr = a; pl_data = d;
        @(posedge clk);
        #1 pl_en = 1'b0;
    endtask

    // Issue one request; mem_ready is low until cycle rdy_at (cycle 1 = first after accept).
    task automatic run_op(input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] wd, input int rdy_at,
                          output int o_lat, output int o_nrd, output int o_nwr, output int o_nreq,
                          output logic o_e, output logic [31:0] o_rd, output logic [31:0] o_ww,
                          output logic o_unst);
        logic              hold;
        logic [ADDR_W-1:0] pa;
        logic              pwe;
        logic [31:0]       pwd;
        hold = 1'b0; pa = '0; pwe = 1'b0; pwd = 32'd0;
        o_lat = 0; o_nrd = 0; o_nwr = 0; o_nreq = 0;
        o_e = 1'b0; o_rd = 32'd0; o_ww = 32'd0; o_unst = 1'b0;
        @(negedge clk);
        req = 1'b1; we = w; size = sz; unsigned_ld = u; addr = a; wdata = wd;
        @(posedge clk);
        #1 req = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            mem_ready = (k >= rdy_at);
            if (hold && (mem_addr !== pa || mem_we !== pwe || mem_wdata !== pwd)) o_unst = 1'b1;
            if (mem_req) o_nreq++;
            if (mem_req && mem_ready) begin
                if (mem_we) begin o_nwr++; o_ww = mem_wdata; end
                else o_nrd++;
            end
            hold = mem_req && !mem_ready; pa = mem_addr; pwe = mem_we; pwd = mem_wdata;
            if (done) begin o_lat = k; o_e = err; o_rd = rdata; break; end
        end
        mem_ready = 1'b1;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if ({busy, done, err, mem_req, mem_we} !== 5'b0) begin n_fail++;
            $display("FAIL reset_ctrl: got %b expected 00000", {busy, done, err, mem_req, mem_we}); end
        n_cmp++; if (rdata !== 32'd0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata); end
        n_cmp++; if (mem_addr !== 7'd0) begin n_fail++; $display("FAIL reset_mem_addr: got %h expected 0", mem_addr); end
        n_cmp++; if (mem_wdata !== 32'd0) begin n_fail++; $display("FAIL reset_mem_wdata: got %h expected 0", mem_wdata); end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_load_ext();
        preload(7'd3, 32'h8899AABB);
        run_op(1'b0, 2'b00, 1'b0, 32'h0D, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (lat !== 2) begin n_fail++; $display("FAIL lb_latency: got %0d expected 2", lat); end
        n_cmp++; if (nrd !== 1 || nwr !== 0) begin n_fail++; $display("FAIL lb_accesses: got rd %0d wr %0d expected rd 1 wr 0", nrd, nwr); end
        n_cmp++; if (rd_o !== 32'hFFFFFFAA) begin n_fail++; $display("FAIL lb_rdata: got %h expected FFFFFFAA", rd_o); end
        n_cmp++; if (e_o !== 1'b0) begin n_fail++; $display("FAIL lb_err: got %b expected 0", e_o); end
        run_op(1'b0, 2'b00, 1'b1, 32'h0D, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (rd_o !== 32'h000000AA) begin n_fail++; $display("FAIL lbu_rdata: got %h expected 000000AA", rd_o); end
        run_op(1'b0, 2'b00, 1'b0, 32'h0C, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (rd_o !== 32'hFFFFFFBB) begin n_fail++; $display("FAIL lb0_rdata: got %h expected FFFFFFBB", rd_o); end
        run_op(1'b0, 2'b01, 1'b0, 32'h0E, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (rd_o !== 32'hFFFF8899) begin n_fail++; $display("FAIL lh_rdata: got %h expected FFFF8899", rd_o); end
        run_op(1'b0, 2'b01, 1'b1, 32'h0C, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (rd_o !== 32'h0000AABB) begin n_fail++; $display("FAIL lhu_rdata: got %h expected 0000AABB", rd_o); end
        run_op(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (rd_o !== 32'h8899AABB || lat !== 2) begin n_fail++;
            $display("FAIL lw_rdata: got %h lat %0d expected 8899AABB lat 2", rd_o, lat); end
    endtask

    task automatic test_store_rmw();
        run_op(1'b1, 2'b01, 1'b0, 32'h0E, 32'hCAFE1234, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (lat !== 3) begin n_fail++; $display("FAIL sh_latency: got %0d expected 3", lat); end
        n_cmp++; if (nrd !== 1 || nwr !== 1) begin n_fail++; $display("FAIL sh_accesses: got rd %0d wr %0d expected rd 1 wr 1", nrd, nwr); end
        n_cmp++; if (ww_o !== 32'h1234AABB) begin n_fail++; $display("FAIL sh_mem_wdata: got %h expected 1234AABB", ww_o); end
        n_cmp++; if (mem[3] !== 32'h1234AABB || e_o !== 1'b0) begin n_fail++;
            $display("FAIL sh_mem_word: got %h err %b expected 1234AABB err 0", mem[3], e_o); end
        run_op(1'b1, 2'b00, 1'b0, 32'h0F, 32'h00000055, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (mem[3] !== 32'h5534AABB || lat !== 3) begin n_fail++;
            $display("FAIL sb_mem_word: got %h lat %0d expected 5534AABB lat 3", mem[3], lat); end
        run_op(1'b1, 2'b10, 1'b0, 32'h14, 32'h01020304, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (mem[5] !== 32'h01020304 || lat !== 2 || nrd !== 0) begin n_fail++;
            $display("FAIL sw_direct: got %h lat %0d rd %0d expected 01020304 lat 2 rd 0", mem[5], lat, nrd); end
    endtask

    task automatic test_errors();
        logic [1:0]  esz [4];
        logic [31:0] ead [4];
        logic        ewe [4];
        esz[0] = 2'b10; ead[0] = 32'h0E;       ewe[0] = 1'b0;
        esz[1] = 2'b11; ead[1] = 32'h0C;       ewe[1] = 1'b0;
        esz[2] = 2'b10; ead[2] = 32'h00000400; ewe[2] = 1'b0;
        esz[3] = 2'b01; ead[3] = 32'h0D;       ewe[3] = 1'b1;
        run_op(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        for (int i = 0; i < 4; i++) begin
            run_op(ewe[i], esz[i], 1'b0, ead[i], 32'hFFFFFFFF, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
            n_cmp++; if (lat !== 1 || e_o !== 1'b1 || nreq !== 0) begin n_fail++;
                $display("FAIL error_%0d: got lat %0d err %b req_cycles %0d expected lat 1 err 1 req_cycles 0", i, lat, e_o, nreq); end
            n_cmp++; if (rd_o !== 32'h01020304) begin n_fail++;
                $display("FAIL error_%0d_rdata: got %h expected 01020304", i, rd_o); end
        end
        n_cmp++; if (mem[3] !== 32'h5534AABB) begin n_fail++; $display("FAIL error_no_write: got %h expected 5534AABB", mem[3]); end
    endtask

    task automatic test_wait_states();
        run_op(1'b1, 2'b10, 1'b0, 32'h08, 32'hDEADBEEF, 6, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (unst !== 1'b0) begin n_fail++; $display("FAIL wait_stable: got unstable %b expected 0", unst); end
        n_cmp++; if (lat !== 7 || nreq !== 6) begin n_fail++;
            $display("FAIL wait_latency: got lat %0d req_cycles %0d expected lat 7 req_cycles 6", lat, nreq); end
        n_cmp++; if (e_o !== 1'b0 || mem[2] !== 32'hDEADBEEF) begin n_fail++;
            $display("FAIL wait_result: got err %b word %h expected err 0 word DEADBEEF", e_o, mem[2]); end
    endtask

    task automatic test_timeout();
        run_op(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        run_op(1'b0, 2'b10, 1'b0, 32'h10, 32'd0, 1000, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (nreq !== 16 || lat !== 17) begin n_fail++;
            $display("FAIL timeout_len: got req_cycles %0d lat %0d expected 16 and 17", nreq, lat); end
        n_cmp++; if (e_o !== 1'b1 || rd_o !== 32'h5534AABB) begin n_fail++;
            $display("FAIL timeout_result: got err %b rdata %h expected err 1 rdata 5534AABB", e_o, rd_o); end
        run_op(1'b0, 2'b10, 1'b0, 32'h14, 32'd0, 16, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (e_o !== 1'b0 || lat !== 17 || rd_o !== 32'h01020304) begin n_fail++;
            $display("FAIL ready_at_expiry: got err %b lat %0d rdata %h expected 0 17 01020304", e_o, lat, rd_o); end
    endtask

    task automatic test_busy_ignore();
        int ndone;
        int nr;
        ndone = 0; nr = 0;
        @(negedge clk);
        req = 1'b1; we = 1'b0; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h0C; wdata = 32'd0;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) req = 1'b0;
            if (done) ndone++;
            if (mem_req && mem_ready && !mem_we) nr++;
        end
        n_cmp++; if (ndone !== 1 || nr !== 1) begin n_fail++;
            $display("FAIL busy_ignore: got done %0d reads %0d expected 1 and 1", ndone, nr); end
        n_cmp++; if (rdata !== 32'h5534AABB) begin n_fail++; $display("FAIL busy_rdata: got %h expected 5534AABB", rdata); end
    endtask

    task automatic test_reset_mid();
        int ndone;
        ndone = 0;
        preload(7'd4, 32'h11111111);
        @(negedge clk);
        mem_ready = 1'b0;
        req = 1'b1; we = 1'b1; size = 2'b10; unsigned_ld = 1'b0; addr = 32'h10; wdata = 32'h99999999;
        @(posedge clk);
        #1 req = 1'b0;
        repeat (3) @(negedge clk);
        n_cmp++; if (mem_req !== 1'b1 || mem_we !== 1'b1) begin n_fail++;
            $display("FAIL in_wr: got req %b we %b expected 1 1", mem_req, mem_we); end
        rst_n = 1'b0;
        #1;
        n_cmp++; if (mem_req !== 1'b0 || busy !== 1'b0) begin n_fail++;
            $display("FAIL async_reset: got req %b busy %b expected 0 0", mem_req, busy); end
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        rst_n = 1'b1;
        mem_ready = 1'b1;
        @(negedge clk);
        if (done) ndone++;
        n_cmp++; if (ndone !== 0 || busy !== 1'b0 || mem[4] !== 32'h11111111) begin n_fail++;
            $display("FAIL reset_abandon: got done %0d busy %b word %h expected 0 0 11111111", ndone, busy, mem[4]); end
        run_op(1'b0, 2'b10, 1'b0, 32'h0C, 32'd0, 1, lat, nrd, nwr, nreq, e_o, rd_o, ww_o, unst);
        n_cmp++; if (lat !== 2 || e_o !== 1'b0 || rd_o !== 32'h5534AABB) begin n_fail++;
            $display("FAIL after_reset_lw: got lat %0d err %b rdata %h expected 2 0 5534AABB", lat, e_o, rd_o); end
    endtask

    initial begin
        n_cmp = 0; n_fail = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; size = 2'b00; unsigned_ld = 1'b0;
        addr = 32'd0; wdata = 32'd0; mem_ready = 1'b1;
        pl_en = 1'b0; pl_addr = '0; pl_data = 32'd0;
        test_reset();
        test_load_ext();
        test_store_rmw();
        test_errors();
        test_wait_states();
        test_timeout();
        test_busy_ignore();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
